// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared constants for the operand-fetch sequencer: addressing modes,
// FSM state encoding, PC register index and autoincrement steps.
package operand_fetch_sequencer_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 4;
  localparam int DEF_PC_REG = 0;

  // source addressing modes
  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;

  // destination addressing modes
  localparam logic AD_REG = 1'b0;
  localparam logic AD_IDX = 1'b1;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SRC_EXT = 3'd1;
  localparam logic [2:0] ST_SRC_REG = 3'd2;
  localparam logic [2:0] ST_SRC_MEM = 3'd3;
  localparam logic [2:0] ST_DST_EXT = 3'd4;
  localparam logic [2:0] ST_DST_REG = 3'd5;
  localparam logic [2:0] ST_DST_MEM = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  // autoincrement steps: bytes step by one except through the PC
  localparam logic [DEF_DATA_W-1:0] BYTE_INC = 16'd1;
  localparam logic [DEF_DATA_W-1:0] WORD_INC = 16'd2;

endpackage

// File: rtl/operand_fetch_sequencer_if.sv
// Register-bank and data-memory port bundle used by the operand-fetch sequencer.
interface operand_fetch_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_wr_en;
  logic [REG_AW-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data, mem_req, mem_addr,
    input  reg_rd_data, mem_ack, mem_rdata
  );

  modport slave (
    input  reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data, mem_req, mem_addr,
    output reg_rd_data, mem_ack, mem_rdata
  );
endinterface

// File: rtl/operand_fetch_sequencer_align.sv
// Byte-lane select and zero-extension for byte instructions; words pass through.
module operand_align
  import operand_fetch_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              addr0,
  input  logic              byte_op,
  output logic [DATA_W-1:0] result
);

  // odd addresses select the high byte, even addresses the low byte
  always_comb begin
    result = data;
    if (byte_op) result = {{(DATA_W-8){1'b0}}, (addr0 ? data[15:8] : data[7:0])};
  end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Operand-fetch sequencer: walks src/dst addressing modes for double-operand
// instructions, fetching extension words, memory operands and applying
// PC / autoincrement write-backs before handing both operands to the ALU.
module operand_fetch_sequencer
  import operand_fetch_sequencer_pkg::*;
#(
  parameter int              DATA_W = DEF_DATA_W,
  parameter int              REG_AW = DEF_REG_AW,
  parameter logic [REG_AW-1:0] PC_REG = REG_AW'(DEF_PC_REG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_AW-1:0] src_reg,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic [1:0]        as_mode,
  input  logic              ad_mode,
  input  logic              byte_op,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] src_operand,
  output logic [DATA_W-1:0] dst_operand,
  output logic [DATA_W-1:0] dst_addr,
  output logic              dst_is_mem,
  operand_fetch_sequencer_if.master bus
);

  logic [2:0]        state;
  logic [REG_AW-1:0] src_r, dst_r;
  logic [1:0]        as_r;
  logic              ad_r, byte_r;
  logic [DATA_W-1:0] ext, ext_pc, addr;

  logic [DATA_W-1:0] reg_aligned, mem_aligned;
  logic              mem_lane0;
  logic [DATA_W-1:0] inc, src_base, dst_base;

  logic [REG_AW-1:0] reg_rd_addr, reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data, mem_addr;
  logic              reg_wr_en, mem_req;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  assign mem_lane0 = (state == ST_SRC_MEM) ? addr[0] : dst_addr[0];
  assign inc       = (byte_r && src_r != PC_REG) ? DATA_W'(BYTE_INC) : DATA_W'(WORD_INC);
  assign src_base  = (src_r == PC_REG) ? ext_pc : bus.reg_rd_data;
  assign dst_base  = (dst_r == PC_REG) ? ext_pc : bus.reg_rd_data;

  operand_align #(.DATA_W(DATA_W)) u_reg_align (
    .data(bus.reg_rd_data), .addr0(1'b0), .byte_op(byte_r), .result(reg_aligned)
  );

  operand_align #(.DATA_W(DATA_W)) u_mem_align (
    .data(bus.mem_rdata), .addr0(mem_lane0), .byte_op(byte_r), .result(mem_aligned)
  );

  // bank and memory strobes decoded from the current state and the memory ack
  always_comb begin
    reg_rd_addr = '0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    reg_wr_data = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    case (state)
      ST_SRC_EXT, ST_DST_EXT: begin
        reg_rd_addr = PC_REG;
        mem_req     = 1'b1;
        mem_addr    = bus.reg_rd_data;
        if (bus.mem_ack) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = PC_REG;
          reg_wr_data = bus.reg_rd_data + DATA_W'(WORD_INC);
        end
      end
      ST_SRC_REG: reg_rd_addr = src_r;
      ST_SRC_MEM: begin
        reg_rd_addr = src_r;
        mem_req     = 1'b1;
        mem_addr    = addr;
        if (bus.mem_ack && as_r == AS_INC) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = src_r;
          reg_wr_data = bus.reg_rd_data + inc;
        end
      end
      ST_DST_REG: reg_rd_addr = dst_r;
      ST_DST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = dst_addr;
      end
      default: ;
    endcase
  end

  assign bus.reg_rd_addr = reg_rd_addr;
  assign bus.reg_wr_en   = reg_wr_en;
  assign bus.reg_wr_addr = reg_wr_addr;
  assign bus.reg_wr_data = reg_wr_data;
  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_addr;

  // sequencing FSM plus the latched instruction fields, addresses and operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      src_r       <= '0;
      dst_r       <= '0;
      as_r        <= '0;
      ad_r        <= 1'b0;
      byte_r      <= 1'b0;
      ext         <= '0;
      ext_pc      <= '0;
      addr        <= '0;
      src_operand <= '0;
      dst_operand <= '0;
      dst_addr    <= '0;
      dst_is_mem  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_r  <= src_reg;
            dst_r  <= dst_reg;
            as_r   <= as_mode;
            ad_r   <= ad_mode;
            byte_r <= byte_op;
            state  <= (as_mode == AS_IDX) ? ST_SRC_EXT : ST_SRC_REG;
          end
        end
        ST_SRC_EXT, ST_DST_EXT: begin
          if (bus.mem_ack) begin
            ext    <= bus.mem_rdata;
            ext_pc <= bus.reg_rd_data;
            state  <= (state == ST_SRC_EXT) ? ST_SRC_REG : ST_DST_REG;
          end
        end
        ST_SRC_REG: begin
          case (as_r)
            AS_REG: begin
              src_operand <= reg_aligned;
              state       <= (ad_r == AD_IDX) ? ST_DST_EXT : ST_DST_REG;
            end
            AS_IDX: begin
              addr  <= src_base + ext;
              state <= ST_SRC_MEM;
            end
            AS_IND, AS_INC: begin
              addr  <= bus.reg_rd_data;
              state <= ST_SRC_MEM;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_SRC_MEM: begin
          if (bus.mem_ack) begin
            src_operand <= mem_aligned;
            state       <= (ad_r == AD_IDX) ? ST_DST_EXT : ST_DST_REG;
          end
        end
        ST_DST_REG: begin
          if (ad_r == AD_REG) begin
            dst_operand <= bus.reg_rd_data;
            dst_is_mem  <= 1'b0;
            state       <= ST_DONE;
          end else begin
            dst_addr   <= dst_base + ext;
            dst_is_mem <= 1'b1;
            state      <= ST_DST_MEM;
          end
        end
        ST_DST_MEM: begin
          if (bus.mem_ack) begin
            dst_operand <= mem_aligned;
            state       <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Self-checking bench for operand_fetch_sequencer: directed vector table,
// hand-written wait-state/reset/restart sequences and randomized operations
// checked against a sequential behavioural model of the addressing rules.
module tb_operand_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  src_reg, dst_reg;
  logic [1:0]  as_mode;
  logic        ad_mode, byte_op;
  logic        busy, done, dst_is_mem;
  logic [15:0] src_operand, dst_operand, dst_addr;

  operand_fetch_sequencer_if bus ();

  operand_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .src_reg(src_reg), .dst_reg(dst_reg), .as_mode(as_mode), .ad_mode(ad_mode), .byte_op(byte_op),
    .busy(busy), .done(done),
    .src_operand(src_operand), .dst_operand(dst_operand),
    .dst_addr(dst_addr), .dst_is_mem(dst_is_mem),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // bench-side register bank, word memory and wait-state generator
  logic [15:0] regs [16];
  logic [15:0] mem [32768];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [15:0] rd_log [$];
  int          wr_cnt = 0, done_cnt = 0, unstable = 0;
  logic        prev_pending = 1'b0;
  logic [15:0] prev_addr = '0;

  assign bus.reg_rd_data = regs[bus.reg_rd_addr];
  assign bus.mem_rdata   = mem[bus.mem_addr[15:1]];
  assign bus.mem_ack     = bus.mem_req && (wcnt >= wait_cfg);

  always @(posedge clk) begin
    if (bus.reg_wr_en) begin
      regs[bus.reg_wr_addr] <= bus.reg_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_req && bus.mem_ack) rd_log.push_back(bus.mem_addr);
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (done) done_cnt <= done_cnt + 1;
    if (prev_pending && !rst && (!bus.mem_req || bus.mem_addr != prev_addr)) unstable <= unstable + 1;
    prev_pending <= bus.mem_req && !bus.mem_ack;
    prev_addr    <= bus.mem_addr;
  end

  int tests = 0, fails = 0;

  // reference model results
  logic [15:0] m_regs [16];
  logic [15:0] exp_reads [$];
  logic [15:0] exp_src, exp_dst, exp_daddr;
  logic        exp_dmem;
  int          exp_lat, exp_nwr;

  // captured DUT results
  logic [15:0] got_src, got_dst, got_daddr;
  logic        got_dmem;
  int          got_lat, wr_base;

  typedef struct {
    logic [3:0]  s, d;
    logic [1:0]  am;
    logic        ad, b;
    logic [3:0]  r0i; logic [15:0] r0v;
    logic [3:0]  r1i; logic [15:0] r1v;
    logic [3:0]  r2i; logic [15:0] r2v;
    logic [15:0] m0a, m0v, m1a, m1v, m2a, m2v, m3a, m3v;
    logic [15:0] e_src, e_dst, e_daddr;
    logic        e_dmem;
    int          e_lat;
    logic [3:0]  c_r; logic [15:0] c_v;
    int          e_nrd, e_nwr;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] fetchOperand(input logic [15:0] a, input logic b);
    logic [15:0] w;
    w = mem[a[15:1]];
    if (!b) return w;
    return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  // walks the addressing rules in program order on a copy of the register file
  task automatic runModel(input logic [3:0] s, input logic [3:0] d, input logic [1:0] am,
                          input logic ad, input logic b, input int w);
    logic [15:0] ext, ext_pc, r, a;
    int n;
    n = 0;
    exp_nwr = 0;
    m_regs = regs;
    exp_reads.delete();
    ext = '0;
    ext_pc = '0;
    if (am == 2'b01) begin
      ext_pc = m_regs[0];
      ext = mem[ext_pc[15:1]];
      exp_reads.push_back(ext_pc);
      m_regs[0] = ext_pc + 16'd2;
      n++; exp_nwr++;
    end
    r = m_regs[s];
    if (am == 2'b00) begin
      exp_src = b ? {8'h00, r[7:0]} : r;
    end else begin
      a = (am == 2'b01) ? (((s == 4'd0) ? ext_pc : r) + ext) : r;
      exp_reads.push_back(a);
      exp_src = fetchOperand(a, b);
      n++;
      if (am == 2'b11) begin
        m_regs[s] = r + ((b && s != 4'd0) ? 16'd1 : 16'd2);
        exp_nwr++;
      end
    end
    if (ad) begin
      ext_pc = m_regs[0];
      ext = mem[ext_pc[15:1]];
      exp_reads.push_back(ext_pc);
      m_regs[0] = ext_pc + 16'd2;
      n++; exp_nwr++;
      a = ((d == 4'd0) ? ext_pc : m_regs[d]) + ext;
      exp_reads.push_back(a);
      exp_dst = fetchOperand(a, b);
      exp_daddr = a;
      exp_dmem = 1'b1;
      n++;
    end else begin
      exp_dst = m_regs[d];
      exp_dmem = 1'b0;
    end
    exp_lat = 3 + n * (1 + w);
  endtask

  // issue one start and count cycles up to done; optionally re-pulse start mid-flight
  task automatic applyStimulus(input logic [3:0] s, input logic [3:0] d, input logic [1:0] am,
                               input logic ad, input logic b, input int intrude);
    @(negedge clk);
    rd_log.delete();
    wr_base = wr_cnt;
    src_reg = s; dst_reg = d; as_mode = am; ad_mode = ad; byte_op = b;
    start = 1'b1;
    got_lat = 0;
    do begin
      @(posedge clk);
      #1;
      got_lat++;
      if (got_lat == intrude) begin
        start = 1'b1;
        src_reg = ~s; dst_reg = ~d; as_mode = ~am; ad_mode = ~ad; byte_op = ~b;
      end else begin
        start = 1'b0;
      end
    end while (!done && got_lat < 300);
    start = 1'b0;
    got_src = src_operand; got_dst = dst_operand;
    got_daddr = dst_addr; got_dmem = dst_is_mem;
    @(negedge clk);
  endtask

  task automatic compareModel(input string tag);
    int bad;
    checkOutput($sformatf("%s src_operand", tag), got_src, exp_src);
    checkOutput($sformatf("%s dst_operand", tag), got_dst, exp_dst);
    checkOutput($sformatf("%s dst_is_mem", tag), got_dmem, exp_dmem);
    if (exp_dmem) checkOutput($sformatf("%s dst_addr", tag), got_daddr, exp_daddr);
    checkOutput($sformatf("%s latency", tag), got_lat, exp_lat);
    checkOutput($sformatf("%s read count", tag), rd_log.size(), exp_reads.size());
    for (int i = 0; i < exp_reads.size() && i < rd_log.size(); i++)
      checkOutput($sformatf("%s read %0d addr", tag, i), rd_log[i], exp_reads[i]);
    checkOutput($sformatf("%s write count", tag), wr_cnt - wr_base, exp_nwr);
    bad = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== m_regs[i]) begin bad = i; break; end
    checkOutput($sformatf("%s regfile R%0d", tag, bad), regs[bad], m_regs[bad]);
  endtask

  task automatic loadVector(input int i);
    for (int k = 0; k < 16; k++) regs[k] = '0;
    regs[vecs[i].r0i] = vecs[i].r0v;
    regs[vecs[i].r1i] = vecs[i].r1v;
    regs[vecs[i].r2i] = vecs[i].r2v;
    mem[vecs[i].m0a[15:1]] = vecs[i].m0v;
    mem[vecs[i].m1a[15:1]] = vecs[i].m1v;
    mem[vecs[i].m2a[15:1]] = vecs[i].m2v;
    mem[vecs[i].m3a[15:1]] = vecs[i].m3v;
  endtask

  task automatic checkVector(input int i);
    string t;
    t = $sformatf("vec%0d", i);
    checkOutput({t, " table src"}, got_src, vecs[i].e_src);
    checkOutput({t, " table dst"}, got_dst, vecs[i].e_dst);
    checkOutput({t, " table dst_is_mem"}, got_dmem, vecs[i].e_dmem);
    if (vecs[i].e_dmem) checkOutput({t, " table dst_addr"}, got_daddr, vecs[i].e_daddr);
    checkOutput({t, " table check reg"}, regs[vecs[i].c_r], vecs[i].c_v);
    checkOutput({t, " table reads"}, rd_log.size(), vecs[i].e_nrd);
    checkOutput({t, " table writes"}, wr_cnt - wr_base, vecs[i].e_nwr);
  endtask

  initial begin
    int dc, wb, seen;
    logic [3:0] s, d;
    logic [1:0] am;
    logic ad, b;

    //            s  d  am    ad b   presets (idx,val) x3                  mem (addr,val) x4                                         src      dst      daddr    dm lat chk reg     nrd nwr
    vecs[0] = '{4'd4, 4'd5, 2'b00, 1'b0, 1'b0, 4'd4, 16'h1234, 4'd5, 16'h00FF, 4'd15, 16'h0000,
                16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h1234, 16'h00FF, 16'h0000, 1'b0, 3, 4'd4, 16'h1234, 0, 0};
    vecs[1] = '{4'd0, 4'd5, 2'b11, 1'b0, 1'b0, 4'd0, 16'h0102, 4'd5, 16'h0000, 4'd15, 16'h0000,
                16'h0102, 16'hBEEF, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'hBEEF, 16'h0000, 16'h0000, 1'b0, 4, 4'd0, 16'h0104, 1, 1};
    vecs[2] = '{4'd6, 4'd7, 2'b01, 1'b1, 1'b0, 4'd0, 16'h1000, 4'd6, 16'h0200, 4'd7, 16'h0300,
                16'h1000, 16'h0010, 16'h0210, 16'h5555, 16'h1002, 16'h0004, 16'h0304, 16'hAAAA,
                16'h5555, 16'hAAAA, 16'h0304, 1'b1, 7, 4'd0, 16'h1004, 4, 2};
    vecs[3] = '{4'd8, 4'd1, 2'b11, 1'b0, 1'b1, 4'd8, 16'h0401, 4'd1, 16'h0000, 4'd15, 16'h0000,
                16'h0400, 16'h12AB, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h0012, 16'h0000, 16'h0000, 1'b0, 4, 4'd8, 16'h0402, 1, 1};
    vecs[4] = '{4'd8, 4'd1, 2'b11, 1'b0, 1'b1, 4'd8, 16'h0400, 4'd1, 16'h0000, 4'd15, 16'h0000,
                16'h0400, 16'h12AB, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h00AB, 16'h0000, 16'h0000, 1'b0, 4, 4'd8, 16'h0401, 1, 1};
    vecs[5] = '{4'd3, 4'd2, 2'b00, 1'b0, 1'b1, 4'd3, 16'hA5C3, 4'd2, 16'h7777, 4'd15, 16'h0000,
                16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h00C3, 16'h7777, 16'h0000, 1'b0, 3, 4'd3, 16'hA5C3, 0, 0};
    vecs[6] = '{4'd9, 4'd10, 2'b10, 1'b0, 1'b0, 4'd9, 16'h2000, 4'd10, 16'h0055, 4'd15, 16'h0000,
                16'h2000, 16'hCAFE, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'hCAFE, 16'h0055, 16'h0000, 1'b0, 4, 4'd9, 16'h2000, 1, 0};
    vecs[7] = '{4'd11, 4'd12, 2'b11, 1'b0, 1'b0, 4'd11, 16'hFFFE, 4'd12, 16'h0001, 4'd15, 16'h0000,
                16'hFFFE, 16'h1357, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h1357, 16'h0001, 16'h0000, 1'b0, 4, 4'd11, 16'h0000, 1, 1};
    vecs[8] = '{4'd0, 4'd2, 2'b01, 1'b0, 1'b0, 4'd0, 16'h3000, 4'd2, 16'h0011, 4'd15, 16'h0000,
                16'h3000, 16'h0100, 16'h3100, 16'h4242, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h4242, 16'h0011, 16'h0000, 1'b0, 5, 4'd0, 16'h3002, 2, 1};
    vecs[9] = '{4'd4, 4'd0, 2'b00, 1'b1, 1'b1, 4'd4, 16'h0000, 4'd0, 16'h4000, 4'd15, 16'h0000,
                16'h4000, 16'h0003, 16'h4002, 16'hBBCC, 16'hFFF0, 16'h0, 16'hFFF0, 16'h0,
                16'h0000, 16'h00BB, 16'h4003, 1'b1, 5, 4'd0, 16'h4002, 2, 1};

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) regs[i] = '0;
    rst = 1'b1; start = 1'b0;
    src_reg = '0; dst_reg = '0; as_mode = '0; ad_mode = 1'b0; byte_op = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset src_operand", src_operand, 0);
    checkOutput("reset dst_operand", dst_operand, 0);
    checkOutput("reset dst_addr", dst_addr, 0);
    checkOutput("reset dst_is_mem", dst_is_mem, 0);
    checkOutput("reset mem_req", bus.mem_req, 0);
    checkOutput("reset reg_wr_en", bus.reg_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed vector table, zero wait states
    for (int i = 0; i < 10; i++) begin
      loadVector(i);
      runModel(vecs[i].s, vecs[i].d, vecs[i].am, vecs[i].ad, vecs[i].b, 0);
      applyStimulus(vecs[i].s, vecs[i].d, vecs[i].am, vecs[i].ad, vecs[i].b, 0);
      checkVector(i);
      checkOutput($sformatf("vec%0d table latency", i), got_lat, vecs[i].e_lat);
      compareModel($sformatf("vec%0d", i));
    end

    // indexed src and dst with three wait states on every read
    wait_cfg = 3;
    loadVector(2);
    runModel(vecs[2].s, vecs[2].d, vecs[2].am, vecs[2].ad, vecs[2].b, 3);
    applyStimulus(vecs[2].s, vecs[2].d, vecs[2].am, vecs[2].ad, vecs[2].b, 0);
    checkOutput("wait3 latency", got_lat, 19);
    compareModel("wait3");

    // reset while SRC_MEM waits for ack on an autoincrement read
    for (int k = 0; k < 16; k++) regs[k] = '0;
    regs[9] = 16'h2000;
    @(negedge clk);
    dc = done_cnt;
    src_reg = 4'd9; dst_reg = 4'd1; as_mode = 2'b11; ad_mode = 1'b0; byte_op = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (bus.mem_req) seen = 1;
      else @(negedge clk);
    end
    checkOutput("rst seq mem_req seen", seen, 1);
    @(negedge clk);
    wb = wr_cnt;
    rst = 1'b1;
    #1;
    checkOutput("rst seq mem_req drops", bus.mem_req, 0);
    checkOutput("rst seq busy drops", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("rst seq no done", done_cnt - dc, 0);
    checkOutput("rst seq no write", wr_cnt - wb, 0);
    checkOutput("rst seq R9 kept", regs[9], 16'h2000);
    checkOutput("rst seq idle", busy, 0);
    wait_cfg = 0;

    // start re-pulsed mid-operation must be ignored
    loadVector(2);
    runModel(vecs[2].s, vecs[2].d, vecs[2].am, vecs[2].ad, vecs[2].b, 0);
    dc = done_cnt;
    applyStimulus(vecs[2].s, vecs[2].d, vecs[2].am, vecs[2].ad, vecs[2].b, 2);
    repeat (5) @(negedge clk);
    compareModel("restart");
    checkOutput("restart single done", done_cnt - dc, 1);
    checkOutput("restart idle after", busy, 0);

    // randomized operations against the model
    for (int t = 0; t < 80; t++) begin
      for (int k = 0; k < 16; k++) regs[k] = 16'($urandom);
      wait_cfg = $urandom_range(0, 2);
      s = 4'($urandom); d = 4'($urandom); am = 2'($urandom);
      ad = 1'($urandom); b = 1'($urandom);
      runModel(s, d, am, ad, b, wait_cfg);
      applyStimulus(s, d, am, ad, b, 0);
      compareModel($sformatf("rand%0d", t));
    end

    checkOutput("mem_req/mem_addr stable while waiting", unstable, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
